fp32_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined fp32 multiplier (`fp32_mult_pipelined`, fixed latency, one issue per cycle) among N requesters in the matrix-multiplier datapath. It accepts at most one request per cycle and drives the multiplier's start/operand inputs from a register. It tracks each in-flight operation's requester in a tag pipeline matched to the multiplier latency, and returns result and flags to the originating requester. It sits between the row/column operand fetch units and the shared multiplier.

---
 rtl/fp32_mult_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fp32_mult_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mult_arbiter.sv
// Round-robin front end sharing one pipelined fp32 multiplier across N_REQ requesters.
// Response lands MULT_LAT+2 cycles after accept; no response backpressure, requesters wait only for a grant.
module fp32_mult_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  mult_start,
    output logic [31:0]           mult_a,
    output logic [31:0]           mult_b,
    input  logic                  mult_done,
    input  logic [31:0]           mult_result,
    input  logic                  mult_overflow,
    input  logic                  mult_underflow,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_result,
    output logic [1:0]            rsp_flags,
    output logic                  busy,
    output logic                  err_spurious,
    output logic                  err_missing,
    output logic [31:0]           op_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  r_ptr;
    logic              r_mult_start;
    logic [31:0]       r_mult_a;
    logic [31:0]       r_mult_b;
    logic [IDX_W-1:0]  r_issue_idx;
    logic [MULT_LAT-1:0] r_tag_vld;
    logic [IDX_W-1:0]  r_tag_idx [MULT_LAT];
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [31:0]       r_rsp_result;
    logic [1:0]        r_rsp_flags;
    logic              r_err_spurious;
    logic              r_err_missing;
    logic [31:0]       r_op_count;

    logic [31:0]       w_a [N_REQ];
    logic [31:0]       w_b [N_REQ];
    logic              w_found;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_accept;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              w_tag_out_vld;
    logic [IDX_W-1:0]  w_tag_out_idx;
    logic [N_REQ-1:0]  w_tag_out_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_a[g] = req_a[32*g +: 32];
        assign w_b[g] = req_b[32*g +: 32];
    end

    // Search from the priority pointer upward, wrapping, and take the first valid requester.
    always_comb begin : arb_search
        logic [IDX_W:0] v_cand;
        v_cand      = '0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (v_cand >= (IDX_W+1)'(N_REQ)) begin
                v_cand = v_cand - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && req_valid[v_cand[IDX_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = v_cand[IDX_W-1:0];
            end
        end
    end

    assign w_accept   = w_found & ~rst;
    assign w_ptr_next = (w_grant_idx == IDX_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_mult_start <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_issue_idx  <= '0;
        end else begin
            r_mult_start <= w_accept;
            if (w_accept) begin
                r_ptr       <= w_ptr_next;
                r_mult_a    <= w_a[w_grant_idx];
                r_mult_b    <= w_b[w_grant_idx];
                r_issue_idx <= w_grant_idx;
            end
        end
    end

    // Stage 0 captures the issue strobe, so the last stage lines up with mult_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_mult_start;
            r_tag_idx[0] <= r_issue_idx;
            for (int s = 1; s < MULT_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    assign w_tag_out_vld = r_tag_vld[MULT_LAT-1];
    assign w_tag_out_idx = r_tag_idx[MULT_LAT-1];

    always_comb begin
        w_tag_out_oh = '0;
        w_tag_out_oh[w_tag_out_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid    <= '0;
            r_rsp_result   <= '0;
            r_rsp_flags    <= '0;
            r_err_spurious <= 1'b0;
            r_err_missing  <= 1'b0;
            r_op_count     <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_tag_out_vld && mult_done) begin
                r_rsp_valid  <= w_tag_out_oh;
                r_rsp_result <= mult_result;
                r_rsp_flags  <= {mult_overflow, mult_underflow};
                r_op_count   <= r_op_count + 32'd1;
            end
            if (w_tag_out_vld && !mult_done) begin
                r_err_missing <= 1'b1;
            end
            if (!w_tag_out_vld && mult_done) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign mult_start   = r_mult_start;
    assign mult_a       = r_mult_a;
    assign mult_b       = r_mult_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_flags    = r_rsp_flags;
    assign err_spurious = r_err_spurious;
    assign err_missing  = r_err_missing;
    assign op_count     = r_op_count;
    assign busy         = r_mult_start | (|r_tag_vld) | (|r_rsp_valid);

endmodule

// File: tb/tb_fp32_mult_arbiter.sv
// Directed and random bench for fp32_mult_arbiter with a behavioural multiplier and response scoreboard.
module tb_fp32_mult_arbiter;

    localparam int N  = 4;
    localparam int L  = 3;
    localparam int RL = L + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              mult_start;
    logic [31:0]       mult_a;
    logic [31:0]       mult_b;
    logic              mult_done;
    logic [31:0]       mult_result;
    logic              mult_overflow;
    logic              mult_underflow;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_result;
    logic [1:0]        rsp_flags;
    logic              busy;
    logic              err_spurious;
    logic              err_missing;
    logic [31:0]       op_count;

    always #5 clk = ~clk;

    fp32_mult_arbiter #(.N_REQ(N), .MULT_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result),
        .mult_overflow(mult_overflow), .mult_underflow(mult_underflow),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .err_spurious(err_spurious), .err_missing(err_missing),
        .op_count(op_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating fp32 multiply for normal operands; returns {overflow, underflow, result}.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(96, 158)), 23'($urandom)};
    endfunction

    // Behavioural multiplier: fixed latency L, reset together with the arbiter.
    logic        supp = 1'b0;
    logic        force_done = 1'b0;
    logic        mm_v [L];
    logic        mm_s [L];
    logic [33:0] mm_r [L];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < L; s++) begin
                mm_v[s] <= 1'b0;
                mm_s[s] <= 1'b0;
                mm_r[s] <= '0;
            end
        end else begin
            mm_v[0] <= mult_start;
            mm_s[0] <= supp;
            mm_r[0] <= fmul(mult_a, mult_b);
            for (int s = 1; s < L; s++) begin
                mm_v[s] <= mm_v[s-1];
                mm_s[s] <= mm_s[s-1];
                mm_r[s] <= mm_r[s-1];
            end
        end
    end

    assign mult_done      = (mm_v[L-1] & ~mm_s[L-1]) | force_done;
    assign mult_result    = mm_r[L-1][31:0];
    assign mult_overflow  = mm_r[L-1][33];
    assign mult_underflow = mm_r[L-1][32];

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [1:0]  flags;
        logic        drop;
        int          cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc   = 0;
    int           m_ptr = 0;
    int           m_cnt = 0;
    logic [N-1:0] m_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arbiter and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] oh;
        logic [33:0]  p;
        logic         found;
        int           g;
        if (rst) begin
            sb.delete();
            m_ptr = 0;
            m_cnt = 0;
            m_acc = '0;
        end else begin
            while (sb.size() > 0 && sb[0].drop && cyc >= sb[0].cyc + RL) void'(sb.pop_front());
            if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    if (!e.drop) oh[e.idx] = 1'b1;
                    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    chk("rsp_latency", 32'(cyc - e.cyc), 32'(RL));
                end
            end else if (sb.size() > 0 && !sb[0].drop && cyc >= sb[0].cyc + RL) begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("rsp_missing", 32'(rsp_valid), 32'(oh));
            end

            found   = 1'b0;
            g       = 0;
            exp_rdy = '0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && req_valid[j]) begin
                    found = 1'b1;
                    g     = j;
                end
            end
            if (found) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            m_acc = exp_rdy;
            if (found) begin
                p       = fmul(req_a[32*g +: 32], req_b[32*g +: 32]);
                e.idx   = g;
                e.res   = p[31:0];
                e.flags = p[33:32];
                e.drop  = supp;
                e.cyc   = cyc;
                sb.push_back(e);
                if (!supp) m_cnt++;
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Lone request from idx with exact-cycle checks of issue, response and busy fall.
    task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic [1:0] exp_flags);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        tick();
        set_op(idx, a, b);
        req_valid = oh;
        @(negedge clk);
        chk("op_grant", 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("op_mult_start", 32'(mult_start), 32'd1);
        chk("op_mult_a", mult_a, a);
        chk("op_mult_b", mult_b, b);
        chk("op_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("op_early", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("op_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("op_rsp_result", rsp_result, exp_res);
        chk("op_rsp_flags", 32'(rsp_flags), 32'(exp_flags));
        chk("op_count", op_count, 32'(m_cnt));
        tick();
        @(negedge clk);
        chk("op_busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [33:0] p;
        logic [31:0] ra;
        logic [31:0] rb;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_mult_a", mult_a, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_spurious", 32'(err_spurious), 32'd0);
        chk("rst_err_missing", 32'(err_missing), 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;

        single_op(2, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00);
        single_op(3, 32'h3F800000, 32'h40A00000, 32'h40A00000, 2'b00);

        for (int i = 0; i < N; i++) set_op(i, rnd_fp(), rnd_fp());
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = '1;
            set_op(i % N, rnd_fp(), rnd_fp());
            @(negedge clk);
            chk("fair_grant", 32'(req_ready), 32'd1 << (i % N));
        end
        tick();
        req_valid = '0;
        drain(30);

        tick();
        set_op(2, rnd_fp(), rnd_fp());
        req_valid = 4'b0100;
        tick();
        set_op(1, rnd_fp(), rnd_fp());
        set_op(3, rnd_fp(), rnd_fp());
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wrap_grant0", 32'(req_ready), 32'b1000);
        tick();
        set_op(3, rnd_fp(), rnd_fp());
        @(negedge clk);
        chk("wrap_grant1", 32'(req_ready), 32'b0010);
        tick();
        set_op(1, rnd_fp(), rnd_fp());
        @(negedge clk);
        chk("wrap_grant2", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        drain(30);

        single_op(0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 2'b10);
        single_op(0, 32'h00800000, 32'h3F000000, 32'h00000000, 2'b01);

        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        @(negedge clk);
        chk("spurious_flag", 32'(err_spurious), 32'd1);
        chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
        chk("spurious_no_missing", 32'(err_missing), 32'd0);

        tick();
        supp = 1'b1;
        set_op(1, 32'h40000000, 32'h40000000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        supp = 1'b0;
        drain(20);
        chk("missing_flag", 32'(err_missing), 32'd1);
        chk("missing_op_count", op_count, 32'(m_cnt));
        single_op(0, 32'h40400000, 32'h40400000, 32'h41100000, 2'b00);
        chk("spurious_sticky", 32'(err_spurious), 32'd1);

        for (int c = 0; c < 60; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, rnd_fp(), rnd_fp());
                end
            end
        end
        tick();
        req_valid = '0;
        drain(30);
        chk("random_op_count", op_count, 32'(m_cnt));

        tick();
        for (int i = 0; i < 3; i++) set_op(i, rnd_fp(), rnd_fp());
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tick();
            req_valid = req_valid & ~m_acc;
        end
        tick();
        rst = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_mult_start", 32'(mult_start), 32'd0);
        chk("midrst_mult_a", mult_a, 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_op_count", op_count, 32'd0);
        chk("midrst_err_spurious", 32'(err_spurious), 32'd0);
        chk("midrst_err_missing", 32'(err_missing), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (8) tick();
        @(negedge clk);
        chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("postrst_err_spurious", 32'(err_spurious), 32'd0);
        ra = rnd_fp();
        rb = rnd_fp();
        p  = fmul(ra, rb);
        single_op(1, ra, rb, p[31:0], p[33:32]);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
